ofmap_collector: RTL and testbench



---
 rtl/ofmap_collector_if.sv | 28 ++
 rtl/ofmap_collector.sv | 161 ++++++++++++++++
 tb/tb_ofmap_collector.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/ofmap_collector_if.sv
// Handshake bundle between the mesh output port, the collector and the host side.
// The slave modport is the collector; the master modport is the driver/consumer.
interface ofmap_collector_if #(
   parameter int PACKET_WIDTH = 33,
   parameter int OUT_W        = 21
);
   logic                    clear;
   logic                    in_valid;
   logic                    in_ready;
   logic [PACKET_WIDTH-1:0] in_packet;
   logic                    out_valid;
   logic                    out_ready;
   logic [OUT_W-1:0]        out_data;
   logic [3:0]              spike_total;
   logic                    done;
   logic                    dup_err;
   logic                    addr_err;

   modport master (
      output clear, in_valid, in_packet, out_ready,
      input  in_ready, out_valid, out_data, spike_total, done, dup_err, addr_err
   );

   modport slave (
      input  clear, in_valid, in_packet, out_ready,
      output in_ready, out_valid, out_data, spike_total, done, dup_err, addr_err
   );
endinterface

// File: rtl/ofmap_collector.sv
// Sink for mesh NoC output packets: fills one slot per (timestep, PE node),
// counts spikes, then drains every slot in ts-major order on a ready/valid stream.
module ofmap_collector #(
   parameter int PACKET_WIDTH = 33,
   parameter int NUM_PE       = 4,
   parameter int NUM_TS       = 2,
   parameter int RESIDUE_LSB  = 16,
   parameter int RESIDUE_W    = 17,
   parameter int OUT_W        = 21
) (
   input  logic             clk,
   input  logic             reset,
   ofmap_collector_if.slave bus
);
   localparam logic [1:0] ST_COLLECT = 2'd0;
   localparam logic [1:0] ST_DRAIN   = 2'd1;
   localparam logic [1:0] ST_DONE    = 2'd2;

   // Slots are addressed as {ts, node}; the mask marks the slots that exist.
   function automatic logic [7:0] slot_mask_f();
      logic [7:0] m;
      m = 8'd0;
      for (int t = 0; t < 2; t++) begin
         for (int n = 0; n < 4; n++) begin
            m[t*4+n] = (t < NUM_TS) && (n < NUM_PE);
         end
      end
      return m;
   endfunction

   localparam logic [7:0] SLOT_MASK = slot_mask_f();
   localparam logic [2:0] LAST_IDX  = 3'((NUM_TS - 1) * 4 + NUM_PE - 1);
   localparam logic [1:0] LAST_NODE = 2'(NUM_PE - 1);

   logic [1:0]           state_r;
   logic [1:0]           state_nxt_s;
   logic [7:0]           filled_r;
   logic [7:0]           filled_nxt_s;
   logic [2:0]           idx_r;
   logic [2:0]           idx_nxt_s;
   logic [3:0]           spike_total_r;
   logic                 done_r;
   logic                 dup_err_r;
   logic                 addr_err_r;
   logic [RESIDUE_W-1:0] res_r [8];
   logic [7:0]           spk_r;

   logic                 pkt_ts_s;
   logic                 pkt_spike_s;
   logic [1:0]           pkt_node_s;
   logic [RESIDUE_W-1:0] pkt_res_s;
   logic [2:0]           pkt_slot_s;
   logic                 pkt_ok_s;
   logic                 in_ready_s;
   logic                 accept_s;
   logic                 write_s;
   logic                 dup_s;
   logic                 bad_s;
   logic                 fill_done_s;
   logic                 out_fire_s;

   assign pkt_ts_s    = bus.in_packet[0];
   assign pkt_spike_s = bus.in_packet[4];
   assign pkt_node_s  = bus.in_packet[6:5];
   assign pkt_res_s   = bus.in_packet[RESIDUE_LSB +: RESIDUE_W];
   assign pkt_slot_s  = {pkt_ts_s, pkt_node_s};
   assign pkt_ok_s    = SLOT_MASK[pkt_slot_s];

   // clear overrides both handshakes so a restart never races a transfer
   assign in_ready_s  = (state_r == ST_COLLECT) && !bus.clear;
   assign accept_s    = bus.in_valid && in_ready_s;
   assign write_s     = accept_s && pkt_ok_s && !filled_r[pkt_slot_s];
   assign dup_s       = accept_s && pkt_ok_s && filled_r[pkt_slot_s];
   assign bad_s       = accept_s && !pkt_ok_s;
   assign out_fire_s  = (state_r == ST_DRAIN) && bus.out_ready && !bus.clear;
   assign fill_done_s = write_s && ((filled_nxt_s & SLOT_MASK) == SLOT_MASK);

   assign bus.in_ready    = in_ready_s;
   assign bus.out_valid   = (state_r == ST_DRAIN);
   assign bus.out_data    = {res_r[idx_r], spk_r[idx_r], idx_r[1:0], idx_r[2]};
   assign bus.spike_total = spike_total_r;
   assign bus.done        = done_r;
   assign bus.dup_err     = dup_err_r;
   assign bus.addr_err    = addr_err_r;

   // Filled-bit update and next drain index (node wraps into the next timestep)
   always_comb begin
      filled_nxt_s = filled_r;
      if (write_s) begin
         filled_nxt_s = filled_r | (8'd1 << pkt_slot_s);
      end else begin
         filled_nxt_s = filled_r;
      end
      if (idx_r[1:0] == LAST_NODE) begin
         idx_nxt_s = {~idx_r[2], 2'b00};
      end else begin
         idx_nxt_s = idx_r + 3'd1;
      end
   end

   // Next-state decode
   always_comb begin
      state_nxt_s = ST_COLLECT;
      case (state_r)
         ST_COLLECT: state_nxt_s = fill_done_s ? ST_DRAIN : ST_COLLECT;
         ST_DRAIN:   state_nxt_s = (out_fire_s && (idx_r == LAST_IDX)) ? ST_DONE : ST_DRAIN;
         ST_DONE:    state_nxt_s = ST_DONE;
         default:    state_nxt_s = ST_COLLECT;
      endcase
   end

   // Round control: state, filled bits, drain index, spike count and done
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r       <= ST_COLLECT;
         filled_r      <= 8'd0;
         idx_r         <= 3'd0;
         spike_total_r <= 4'd0;
         done_r        <= 1'b0;
      end else if (bus.clear) begin
         state_r       <= ST_COLLECT;
         filled_r      <= 8'd0;
         idx_r         <= 3'd0;
         spike_total_r <= 4'd0;
         done_r        <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         filled_r <= filled_nxt_s;
         done_r   <= (state_nxt_s == ST_DONE);
         if (out_fire_s && (idx_r != LAST_IDX)) begin
            idx_r <= idx_nxt_s;
         end
         if (write_s && pkt_spike_s && (spike_total_r != 4'd15)) begin
            spike_total_r <= spike_total_r + 4'd1;
         end
      end
   end

   // Sticky error flags survive clear; only reset wipes them
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dup_err_r  <= 1'b0;
         addr_err_r <= 1'b0;
      end else begin
         if (dup_s) begin
            dup_err_r <= 1'b1;
         end
         if (bad_s) begin
            addr_err_r <= 1'b1;
         end
      end
   end

   // Slot payload; only read where the matching filled bit is set
   always_ff @(posedge clk) begin
      if (write_s) begin
         res_r[pkt_slot_s] <= pkt_res_s;
         spk_r[pkt_slot_s] <= pkt_spike_s;
      end
   end
endmodule

// File: tb/tb_ofmap_collector.sv
// Randomized self-checking bench for ofmap_collector against a slot-table model.
module tb_ofmap_collector;
   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   ofmap_collector_if #(.PACKET_WIDTH(33), .OUT_W(21)) bus ();
   ofmap_collector_if #(.PACKET_WIDTH(33), .OUT_W(21)) bus3 ();

   ofmap_collector dut (.clk(clk), .reset(reset), .bus(bus));
   ofmap_collector #(.NUM_PE(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

   // Reference model: a plain table of slots indexed [ts][node]
   logic [16:0] m_res  [2][4];
   logic        m_spk  [2][4];
   logic        m_fill [2][4];
   int          m_spikes;
   logic        m_dup, m_addr, m_collect;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int t = 0; t < 2; t++)
         for (int n = 0; n < 4; n++) m_fill[t][n] = 1'b0;
      m_spikes  = 0;
      m_collect = 1'b1;
   endtask

   function automatic logic all_filled();
      logic a = 1'b1;
      for (int t = 0; t < 2; t++)
         for (int n = 0; n < 4; n++) a = a & m_fill[t][n];
      return a;
   endfunction

   function automatic logic [32:0] mk_pkt(input int t, input int n, input logic s, input logic [16:0] r);
      logic [32:0] p;
      p       = {1'b0, $urandom()};
      p[0]    = t[0];
      p[4]    = s;
      p[6:5]  = n[1:0];
      p[32:16] = r;
      return p;
   endfunction

   task automatic push(input int t, input int n, input logic s, input logic [16:0] r);
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_packet = mk_pkt(t, n, s, r);
      bus.out_ready = 1'b0;
      #1;
      check("in_ready", 32'(bus.in_ready), 32'(m_collect));
      check("spike_total", 32'(bus.spike_total), 32'(m_spikes));
      check("dup_err", 32'(bus.dup_err), 32'(m_dup));
      if (m_collect) begin
         if (m_fill[t][n]) begin
            m_dup = 1'b1;
         end else begin
            m_fill[t][n] = 1'b1;
            m_res[t][n]  = r;
            m_spk[t][n]  = s;
            if (s && m_spikes < 15) m_spikes++;
            if (all_filled()) m_collect = 1'b0;
         end
      end
      @(posedge clk);
   endtask

   task automatic drain(input int mode, input int stop_after);
      logic [20:0] exp_w [8];
      logic [3:0]  pat = 4'b1001;
      logic        r;
      int          k = 0;
      int          cyc = 0;
      for (int t = 0; t < 2; t++)
         for (int n = 0; n < 4; n++)
            exp_w[t*4+n] = {m_res[t][n], m_spk[t][n], 2'(n), 1'(t)};
      while (k < stop_after && cyc < 200) begin
         @(negedge clk);
         cyc++;
         case (mode)
            0:       r = 1'b1;
            1:       r = pat[3 - ((cyc - 1) % 4)];
            default: r = 1'($urandom_range(0, 1));
         endcase
         bus.in_valid  = 1'b0;
         bus.out_ready = r;
         #1;
         check("out_valid", 32'(bus.out_valid), 32'(1'b1));
         check("in_ready_drain", 32'(bus.in_ready), 32'(1'b0));
         check("out_data", 32'(bus.out_data), 32'(exp_w[k]));
         if (r) k++;
      end
      if (k < stop_after) check("drain_timeout", 32'(k), 32'(stop_after));
      if (stop_after == 8) begin
         @(negedge clk);
         bus.out_ready = 1'b0;
         #1;
         check("done", 32'(bus.done), 32'(1'b1));
         check("out_valid_done", 32'(bus.out_valid), 32'(1'b0));
         check("spike_total_end", 32'(bus.spike_total), 32'(m_spikes));
      end
   endtask

   task automatic do_clear(input logic with_valid);
      @(negedge clk);
      bus.clear     = 1'b1;
      bus.in_valid  = with_valid;
      bus.in_packet = mk_pkt(0, 1, 1'b1, 17'h00003);
      bus.out_ready = 1'b1;
      #1;
      check("in_ready_clear", 32'(bus.in_ready), 32'(1'b0));
      @(negedge clk);
      bus.clear     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      #1;
      model_clear();
      check("clear_spikes", 32'(bus.spike_total), 32'(0));
      check("clear_done", 32'(bus.done), 32'(1'b0));
      check("clear_in_ready", 32'(bus.in_ready), 32'(1'b1));
      check("clear_dup_err", 32'(bus.dup_err), 32'(m_dup));
      check("clear_addr_err", 32'(bus.addr_err), 32'(m_addr));
   endtask

   task automatic random_round(input int count);
      int order [8];
      int j, tmp;
      for (int i = 0; i < 8; i++) order[i] = i;
      for (int i = 7; i > 0; i--) begin
         j = $urandom_range(0, i);
         tmp = order[i]; order[i] = order[j]; order[j] = tmp;
      end
      for (int i = 0; i < count; i++)
         push(order[i] / 4, order[i] % 4, 1'($urandom_range(0, 1)), 17'($urandom()));
   endtask

   initial begin
      bus.clear = 1'b0;  bus.in_valid = 1'b0;  bus.in_packet = 33'd0;  bus.out_ready = 1'b0;
      bus3.clear = 1'b0; bus3.in_valid = 1'b0; bus3.in_packet = 33'd0; bus3.out_ready = 1'b0;
      reset = 1'b1;
      m_dup = 1'b0; m_addr = 1'b0;
      model_clear();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_in_ready", 32'(bus.in_ready), 32'(1'b1));
      check("rst_out_valid", 32'(bus.out_valid), 32'(1'b0));
      check("rst_done", 32'(bus.done), 32'(1'b0));
      check("rst_spikes", 32'(bus.spike_total), 32'(0));
      check("rst_dup_err", 32'(bus.dup_err), 32'(1'b0));
      check("rst_addr_err", 32'(bus.addr_err), 32'(1'b0));

      // In-order round, back-to-back input and output
      for (int t = 0; t < 2; t++)
         for (int n = 0; n < 4; n++)
            push(t, n, 1'(n % 2), 17'(16 * n + t));
      drain(0, 8);
      check("round1_spikes", 32'(m_spikes), 32'(4));
      @(negedge clk); #1;
      check("done_hold", 32'(bus.done), 32'(1'b1));
      check("done_in_ready", 32'(bus.in_ready), 32'(1'b0));

      // Out-of-order round with a duplicate, stalled drain
      do_clear(1'b0);
      push(1, 3, 1'b1, 17'($urandom()));
      push(1, 0, 1'b0, 17'($urandom()));
      push(0, 2, 1'b1, 17'h00005);
      push(1, 2, 1'b0, 17'($urandom()));
      push(0, 1, 1'b1, 17'($urandom()));
      push(0, 3, 1'b0, 17'($urandom()));
      push(1, 1, 1'b1, 17'($urandom()));
      push(0, 2, 1'b0, 17'h1FFFF);
      push(0, 0, 1'b1, 17'($urandom()));
      check("dup_seen", 32'(m_dup), 32'(1'b1));
      drain(1, 8);

      // Partial round aborted by clear with a colliding packet, then a random round
      do_clear(1'b0);
      random_round(3);
      do_clear(1'b1);
      random_round(8);
      drain(2, 8);

      // Asynchronous reset in the middle of a drain
      do_clear(1'b0);
      random_round(8);
      drain(0, 3);
      #2;
      reset = 1'b1;
      bus.out_ready = 1'b0;
      #1;
      check("rst_mid_out_valid", 32'(bus.out_valid), 32'(1'b0));
      check("rst_mid_done", 32'(bus.done), 32'(1'b0));
      check("rst_mid_in_ready", 32'(bus.in_ready), 32'(1'b1));
      check("rst_mid_dup_err", 32'(bus.dup_err), 32'(1'b0));
      @(negedge clk);
      reset = 1'b0;

      // Three-node instance: node 3 is out of range
      @(negedge clk);
      bus3.in_valid  = 1'b1;
      bus3.in_packet = mk_pkt(0, 3, 1'b1, 17'h0ABCD);
      #1;
      check("n3_in_ready", 32'(bus3.in_ready), 32'(1'b1));
      @(negedge clk);
      bus3.in_packet = mk_pkt(1, 2, 1'b1, 17'h00042);
      #1;
      check("n3_addr_err", 32'(bus3.addr_err), 32'(1'b1));
      check("n3_dropped", 32'(bus3.spike_total), 32'(0));
      @(negedge clk);
      bus3.in_valid = 1'b0;
      #1;
      check("n3_valid_spike", 32'(bus3.spike_total), 32'(1));
      check("n3_addr_sticky", 32'(bus3.addr_err), 32'(1'b1));
      check("n3_dup_err", 32'(bus3.dup_err), 32'(1'b0));
      check("n3_collecting", 32'(bus3.in_ready), 32'(1'b1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
